// File: rtl/logic_axi4_lite_register_bank.sv
// AXI4-Lite slave holding a bank of software-visible registers.
// Decoupled AW/W holding buffers, registered B and R channels.
package logic_axi4_lite_pkg;
  typedef logic [2:0] access_t;
  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } response_t;
endpackage

module logic_axi4_lite_register_bank
  import logic_axi4_lite_pkg::*;
#(
  parameter int DATA_BYTES    = 4,
  parameter int ADDRESS_WIDTH = 10,
  parameter int REGISTERS     = 8,
  parameter logic [DATA_BYTES*8-1:0] RESET_VALUE = '0
) (
  input  logic aclk,
  input  logic areset,
  input  logic awvalid,
  input  logic [ADDRESS_WIDTH-1:0] awaddr,
  input  access_t awprot,
  output logic awready,
  input  logic wvalid,
  input  logic [DATA_BYTES-1:0][7:0] wdata,
  input  logic [DATA_BYTES-1:0] wstrb,
  output logic wready,
  output logic bvalid,
  output response_t bresp,
  input  logic bready,
  input  logic arvalid,
  input  logic [ADDRESS_WIDTH-1:0] araddr,
  input  access_t arprot,
  output logic arready,
  output logic rvalid,
  output logic [DATA_BYTES-1:0][7:0] rdata,
  output response_t rresp,
  input  logic rready,
  output logic [REGISTERS-1:0][DATA_BYTES-1:0][7:0] registers,
  output logic [REGISTERS-1:0] written
);

  localparam int OFF = $clog2(DATA_BYTES);
  localparam int IW  = ADDRESS_WIDTH - OFF;

  logic aw_full;
  logic [IW-1:0] aw_idx;
  logic w_full;
  logic [DATA_BYTES-1:0][7:0] w_data;
  logic [DATA_BYTES-1:0] w_strb;

  logic [REGISTERS-1:0] w_sel;
  logic [DATA_BYTES-1:0][7:0] rd_word;
  logic rd_hit;
  logic [IW-1:0] ar_idx;
  logic aw_hs;
  logic w_hs;
  logic ar_hs;
  logic commit;

  // Protection bits and sub-word address bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{awprot, arprot, awaddr, araddr};

  assign awready = !aw_full && !areset;
  assign wready  = !w_full && !areset;
  assign arready = (!rvalid || rready) && !areset;

  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign ar_hs  = arvalid && arready;
  assign commit = aw_full && w_full && (!bvalid || bready);
  assign ar_idx = araddr[ADDRESS_WIDTH-1:OFF];

  // Out-of-range indices match no entry: empty select, zero read data.
  always_comb begin
    w_sel   = '0;
    rd_word = '0;
    rd_hit  = 1'b0;
    for (int i = 0; i < REGISTERS; i++) begin
      if (aw_idx == IW'(i)) begin
        w_sel[i] = 1'b1;
      end
      if (ar_idx == IW'(i)) begin
        rd_word = registers[i];
        rd_hit  = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      aw_full <= 1'b0;
      aw_idx  <= '0;
      w_full  <= 1'b0;
      w_data  <= '0;
      w_strb  <= '0;
    end else begin
      if (commit) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
      end
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_idx  <= awaddr[ADDRESS_WIDTH-1:OFF];
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= wdata;
        w_strb <= wstrb;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      registers <= {REGISTERS{RESET_VALUE}};
      written   <= '0;
    end else begin
      written <= commit ? w_sel : '0;
      for (int i = 0; i < REGISTERS; i++) begin
        for (int b = 0; b < DATA_BYTES; b++) begin
          if (commit && w_sel[i] && w_strb[b]) begin
            registers[i][b] <= w_data[b];
          end
        end
      end
    end
  end

  // A commit in the handshake cycle keeps bvalid high with the new response.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      bvalid <= 1'b0;
      bresp  <= OKAY;
    end else if (commit) begin
      bvalid <= 1'b1;
      bresp  <= (|w_sel) ? OKAY : SLVERR;
    end else if (bready) begin
      bvalid <= 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= OKAY;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      rdata  <= rd_word;
      rresp  <= rd_hit ? OKAY : SLVERR;
    end else if (rready) begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_logic_axi4_lite_register_bank.sv
// Bench for logic_axi4_lite_register_bank: directed plan plus
// randomized writes/reads against an array model of the bank.
module tb_logic_axi4_lite_register_bank;
  import logic_axi4_lite_pkg::*;

  logic aclk = 1'b0;
  logic areset;
  logic awvalid;
  logic [9:0] awaddr;
  access_t awprot;
  logic awready;
  logic wvalid;
  logic [3:0][7:0] wdata;
  logic [3:0] wstrb;
  logic wready;
  logic bvalid;
  response_t bresp;
  logic bready;
  logic arvalid;
  logic [9:0] araddr;
  access_t arprot;
  logic arready;
  logic rvalid;
  logic [3:0][7:0] rdata;
  response_t rresp;
  logic rready;
  logic [7:0][3:0][7:0] registers;
  logic [7:0] written;

  logic_axi4_lite_register_bank #(
    .DATA_BYTES(4),
    .ADDRESS_WIDTH(10),
    .REGISTERS(8),
    .RESET_VALUE(32'h0)
  ) dut (
    .aclk(aclk), .areset(areset),
    .awvalid(awvalid), .awaddr(awaddr), .awprot(awprot),
    .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb),
    .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .arvalid(arvalid), .araddr(araddr), .arprot(arprot),
    .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp),
    .rready(rready),
    .registers(registers), .written(written)
  );

  always #5 aclk = ~aclk;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] model [8];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s_reg%0d", tag, i), registers[i], model[i]);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic do_write(input logic [9:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly,
                          input int w_dly);
    bit aw_done = 0;
    bit w_done = 0;
    int c = 0;
    int idx = int'(addr[9:2]);
    while (!(aw_done && w_done) && c < 40) begin
      @(negedge aclk);
      awvalid = !aw_done && c >= aw_dly;
      awaddr = addr;
      awprot = access_t'($urandom);
      wvalid = !w_done && c >= w_dly;
      wdata = data;
      wstrb = strb;
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      c++;
    end
    chk("wr_accept_timeout", {aw_done, w_done}, 2'b11);
    @(negedge aclk);
    awvalid = 0;
    wvalid = 0;
    c = 0;
    while (!bvalid && c < 10) begin
      @(negedge aclk);
      c++;
    end
    chk("b_timeout", bvalid, 1'b1);
    chk("bresp", bresp, idx < 8 ? OKAY : SLVERR);
    chk("written_pulse", written, idx < 8 ? (8'h1 << idx) : 8'h0);
    if (idx < 8) model[idx] = merge(model[idx], data, strb);
    @(negedge aclk);
    chk("written_clear", written, 8'h0);
  endtask

  task automatic do_read(input logic [9:0] addr);
    int c = 0;
    int idx = int'(addr[9:2]);
    @(negedge aclk);
    arvalid = 1;
    araddr = addr;
    arprot = access_t'($urandom);
    while (!arready && c < 20) begin
      @(negedge aclk);
      c++;
    end
    chk("ar_timeout", arready, 1'b1);
    @(negedge aclk);
    arvalid = 0;
    chk("rvalid", rvalid, 1'b1);
    chk("rdata", rdata, idx < 8 ? model[idx] : 32'h0);
    chk("rresp", rresp, idx < 8 ? OKAY : SLVERR);
  endtask

  initial begin
    areset = 1;
    awvalid = 0; awaddr = 0; awprot = 0;
    wvalid = 0; wdata = 0; wstrb = 0;
    arvalid = 0; araddr = 0; arprot = 0;
    bready = 1; rready = 1;
    for (int i = 0; i < 8; i++) model[i] = 32'h0;

    repeat (2) @(negedge aclk);
    chk("rst_awready", awready, 1'b0);
    chk("rst_wready", wready, 1'b0);
    chk("rst_arready", arready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    areset = 0;
    #1;
    chk("rel_awready", awready, 1'b1);
    chk("rel_wready", wready, 1'b1);
    chk("rel_arready", arready, 1'b1);
    chk("rst_written", written, 8'h0);
    check_regs("rst");

    do_write(10'h004, 32'hDEADBEEF, 4'hF, 0, 0);
    check_regs("wr1");
    do_read(10'h004);

    do_write(10'h008, 32'hAABBCCDD, 4'hF, 0, 0);
    do_write(10'h008, 32'h11223344, 4'b0101, 3, 0);
    chk("strb_merge", registers[2], 32'hAA22CC44);

    do_write(10'h3FC, 32'h12345678, 4'hF, 0, 0);
    do_read(10'h3FC);
    check_regs("oor");

    // B backpressure with a second write queued behind it
    @(negedge aclk);
    bready = 0;
    awvalid = 1; awaddr = 10'h00C;
    wvalid = 1; wdata = 32'hCAFE0001; wstrb = 4'hF;
    @(negedge aclk);
    awvalid = 0; wvalid = 0;
    @(negedge aclk);
    chk("bp_bvalid", bvalid, 1'b1);
    chk("bp_written", written, 8'h08);
    model[3] = 32'hCAFE0001;
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      chk("bp_hold_bvalid", bvalid, 1'b1);
      chk("bp_hold_bresp", bresp, OKAY);
    end
    awvalid = 1; awaddr = 10'h010;
    wvalid = 1; wdata = 32'hCAFE0002; wstrb = 4'hF;
    @(negedge aclk);
    awvalid = 0; wvalid = 0;
    chk("bp_awready_full", awready, 1'b0);
    chk("bp_wready_full", wready, 1'b0);
    chk("bp_written_none", written, 8'h0);
    @(negedge aclk);
    chk("bp_awready_full2", awready, 1'b0);
    chk("bp_bvalid2", bvalid, 1'b1);
    bready = 1;
    @(negedge aclk);
    chk("bp_bvalid_cont", bvalid, 1'b1);
    chk("bp_written2", written, 8'h10);
    model[4] = 32'hCAFE0002;
    @(negedge aclk);
    chk("bp_bvalid_done", bvalid, 1'b0);
    chk("bp_awready_back", awready, 1'b1);
    check_regs("bp");

    // Back-to-back reads, then R backpressure
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
      if (k > 0) begin
        chk("b2b_rvalid", rvalid, 1'b1);
        chk("b2b_rdata", rdata, model[k-1]);
      end
      chk("b2b_arready", arready, 1'b1);
      arvalid = 1;
      araddr = 10'(4 * k);
    end
    @(negedge aclk);
    arvalid = 0;
    rready = 0;
    #1;
    chk("b2b_rvalid_last", rvalid, 1'b1);
    chk("b2b_rdata_last", rdata, model[3]);
    chk("rbp_arready", arready, 1'b0);
    repeat (2) begin
      @(negedge aclk);
      chk("rbp_rvalid", rvalid, 1'b1);
      chk("rbp_rdata", rdata, model[3]);
    end
    rready = 1;
    @(negedge aclk);
    chk("rbp_release", rvalid, 1'b0);

    // Same-cycle read and write of one register sees the old value
    @(negedge aclk);
    awvalid = 1; awaddr = 10'h014;
    wvalid = 1; wdata = 32'h0BADF00D; wstrb = 4'hF;
    @(negedge aclk);
    awvalid = 0; wvalid = 0;
    arvalid = 1; araddr = 10'h014;
    @(negedge aclk);
    arvalid = 0;
    chk("rw_same_rdata", rdata, model[5]);
    chk("rw_same_bvalid", bvalid, 1'b1);
    model[5] = 32'h0BADF00D;
    @(negedge aclk);
    check_regs("rw_same");

    for (int n = 0; n < 30; n++) begin
      int idx;
      logic [9:0] addr;
      idx = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 7)
                                       : $urandom_range(8, 255);
      addr = {8'(idx), 2'($urandom)};
      if ($urandom_range(0, 1) == 0)
        do_write(addr, $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3), $urandom_range(0, 3));
      else
        do_read(addr);
    end
    check_regs("rand");

    // Reset with a buffered AW and a stalled R beat
    @(negedge aclk);
    rready = 0;
    arvalid = 1; araddr = 10'h004;
    awvalid = 1; awaddr = 10'h000;
    @(negedge aclk);
    arvalid = 0; awvalid = 0;
    chk("mid_rvalid_pre", rvalid, 1'b1);
    chk("mid_awfull_pre", awready, 1'b0);
    #2;
    areset = 1;
    #1;
    chk("mid_rvalid", rvalid, 1'b0);
    chk("mid_awready", awready, 1'b0);
    chk("mid_arready", arready, 1'b0);
    for (int i = 0; i < 8; i++) model[i] = 32'h0;
    check_regs("mid");
    @(negedge aclk);
    areset = 0;
    rready = 1;
    repeat (4) begin
      @(negedge aclk);
      chk("post_bvalid", bvalid, 1'b0);
      chk("post_rvalid", rvalid, 1'b0);
    end
    chk("post_awready", awready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
